addr_ft_chunked: RTL and testbench

- Parametrised, fault-resilient successor to the team's fixed 4-bit unsigned adder.
- Adds two W-bit unsigned operands plus carry-in, CHUNK bits per cycle, on two structurally independent replica datapaths (primary and shadow).
- Replicas are compared every cycle; a mismatched chunk is recomputed up to MAX_RETRY times before being committed with an error flag.
- Sits between valid/ready producer and consumer stages; includes a fault-injection hook for resilience characterisation.

---
 rtl/addr_ft_chunked.sv | 214 +++++++++++++++++++++
 tb/tb_addr_ft_chunked.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_ft_chunked.sv
// addr_ft_chunked: chunked W-bit unsigned adder (a + b + cin) with a primary
// and a shadow replica datapath. The two replicas are compared every ADD
// cycle. A chunk whose replicas disagree is recomputed up to MAX_RETRY times.
// If the replicas still disagree, the primary result is committed and err is set.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, cin)
//   out_valid/out_ready  result handshake (sum, err)
//   sum [W:0]            a + b + cin, MSB is carry-out
//   err                  a chunk was committed while the replicas disagreed
//                        (only meaningful while out_valid is high)
//   fault_cnt            saturating count of replica mismatches since reset
//   fi_en, fi_mask       XOR mask on the shadow {carry,sum} chunk, ADD only
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// ADD    | one chunk attempt per cycle, idx/retry advance
// DONE   | result held, out_valid high until consumer accepts

module addr_ft_chunked #(
    parameter int W         = 8,
    parameter int CHUNK     = 4,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       sum,
    output logic             err,
    output logic [CNT_W-1:0] fault_cnt,
    input  logic             fi_en,
    input  logic [CHUNK:0]   fi_mask
);

    localparam int NCH   = W / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RET_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
    localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRY);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [RET_W-1:0]   r_retry;
    logic [W:0]         r_sum;
    logic               r_err;
    logic [CNT_W-1:0]   r_fault_cnt;

    logic               w_accept;
    logic               w_mismatch;
    logic               w_commit;
    logic               w_commit_err;
    logic               w_retry_inc;

    // Primary replica: indexed operand mux and a behavioural adder.
    logic [CHUNK-1:0]   w_pa;
    logic [CHUNK-1:0]   w_pb;
    logic [CHUNK:0]     w_prim;

    // Shadow replica: AND-OR operand select and an explicit ripple chain, so
    // it shares no structure with the primary; keep stops synthesis merging it.
    (* keep = "true" *) logic [CHUNK-1:0] w_sa;
    (* keep = "true" *) logic [CHUNK-1:0] w_sb;
    (* keep = "true" *) logic [CHUNK:0]   w_sh_raw;
    logic [CHUNK:0]     w_shadow;

    always_comb begin
        w_pa = '0;
        w_pb = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_pa = r_a[k*CHUNK +: CHUNK];
                w_pb = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    assign w_prim = {1'b0, w_pa} + {1'b0, w_pb} + {{CHUNK{1'b0}}, r_carry};

    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int k = 0; k < NCH; k++) begin
            w_sa = w_sa | (r_a[k*CHUNK +: CHUNK] & {CHUNK{r_idx == IDX_W'(k)}});
            w_sb = w_sb | (r_b[k*CHUNK +: CHUNK] & {CHUNK{r_idx == IDX_W'(k)}});
        end
    end

    always_comb begin
        logic v_c;
        w_sh_raw = '0;
        v_c      = r_carry;
        for (int i = 0; i < CHUNK; i++) begin
            w_sh_raw[i] = w_sa[i] ^ w_sb[i] ^ v_c;
            v_c         = (w_sa[i] & w_sb[i]) | (v_c & (w_sa[i] ^ w_sb[i]));
        end
        w_sh_raw[CHUNK] = v_c;
    end

    assign w_shadow = w_sh_raw ^ (fi_en ? fi_mask : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_mismatch   = 1'b0;
        w_commit     = 1'b0;
        w_commit_err = 1'b0;
        w_retry_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                if (w_prim != w_shadow) begin
                    w_mismatch = 1'b1;
                    if (r_retry < RET_MAX) begin
                        w_retry_inc = 1'b1;
                    end else begin
                        // Out of retries: trust the primary and flag it.
                        w_commit     = 1'b1;
                        w_commit_err = 1'b1;
                    end
                end else begin
                    w_commit = 1'b1;
                end
                if (w_commit && (r_idx == LAST_IDX)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_sum       <= '0;
            r_err       <= 1'b0;
            r_fault_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_idx   <= '0;
                r_retry <= '0;
                r_err   <= 1'b0;
            end
            if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_commit) begin
                for (int k = 0; k < NCH; k++) begin
                    if (r_idx == IDX_W'(k)) begin
                        r_sum[k*CHUNK +: CHUNK] <= w_prim[CHUNK-1:0];
                    end
                end
                if (r_idx == LAST_IDX) begin
                    r_sum[W] <= w_prim[CHUNK];
                end
                r_carry <= w_prim[CHUNK];
                r_retry <= '0;
                r_idx   <= r_idx + 1'b1;
                if (w_commit_err) begin
                    r_err <= 1'b1;
                end
            end
            if (w_mismatch && (r_fault_cnt != {CNT_W{1'b1}})) begin
                r_fault_cnt <= r_fault_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign err       = r_err & out_valid;
    assign fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_addr_ft_chunked.sv
// Directed bench for addr_ft_chunked (W=8, CHUNK=4, MAX_RETRY=2, CNT_W=8).
module tb_addr_ft_chunked;

    localparam int W = 8;
    localparam int CHUNK = 4;
    localparam int MAX_RETRY = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [W:0]       sum;
    logic             err;
    logic [CNT_W-1:0] fault_cnt;
    logic             fi_en;
    logic [CHUNK:0]   fi_mask;

    int total = 0;
    int bad   = 0;

    addr_ft_chunked #(.W(W), .CHUNK(CHUNK), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .err(err), .fault_cnt(fault_cnt), .fi_en(fi_en), .fi_mask(fi_mask)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task apply_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fi_en = 1'b0; fi_mask = '0;
        a = '0; b = '0; cin = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Offers one operation, keeps fi_en high for the first fi_n ADD cycles,
    // returns cycles from the accepting edge to out_valid (-1 on timeout).
    task run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                input int fi_n, input logic [CHUNK:0] m, output int lat);
        a = ia; b = ib; cin = ic; fi_mask = m; fi_en = (fi_n > 0);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            tick;
            lat++;
            if (lat >= fi_n) fi_en = 1'b0;
        end
        if (out_valid !== 1'b1) lat = -1;
        fi_en = 1'b0;
    endtask

    task release_out;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fi_en = 1'b0; fi_mask = '0;
        a = '0; b = '0; cin = 1'b0;
        tick;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (sum !== 9'h000) begin bad++; $display("FAIL reset_sum: got %h want 000", sum); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL reset_fault_cnt: got %0d want 0", fault_cnt); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task test_no_fault;
        int lat;
        run_op(8'hFF, 8'h01, 1'b0, 0, '0, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL nofault_latency: got %0d want 2", lat); end
        total++; if (sum !== 9'h100) begin bad++; $display("FAIL nofault_sum: got %h want 100", sum); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL nofault_err: got %b want 0", err); end
        total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL nofault_fault_cnt: got %0d want 0", fault_cnt); end
        release_out;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nofault_drop_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nofault_in_ready: got %b want 1", in_ready); end
    endtask

    task test_backpressure;
        int lat;
        run_op(8'hFF, 8'hFF, 1'b1, 0, '0, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL bp_latency: got %0d want 2", lat); end
        for (int i = 0; i < 5; i++) begin
            total++; if (sum !== 9'h1FF) begin bad++; $display("FAIL bp_sum_hold[%0d]: got %h want 1ff", i, sum); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            tick;
        end
        release_out;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_handshake_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_handshake_in_ready: got %b want 1", in_ready); end
    endtask

    task test_single_retry;
        int lat;
        run_op(8'h3C, 8'h0A, 1'b0, 1, 5'h01, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL retry1_latency: got %0d want 3", lat); end
        total++; if (sum !== 9'h046) begin bad++; $display("FAIL retry1_sum: got %h want 046", sum); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL retry1_err: got %b want 0", err); end
        total++; if (fault_cnt !== 8'd1) begin bad++; $display("FAIL retry1_fault_cnt: got %0d want 1", fault_cnt); end
        release_out;
    endtask

    task test_persistent_fault;
        int lat;
        apply_reset;
        run_op(8'h12, 8'h34, 1'b0, 1000, 5'h10, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL persist_latency: got %0d want 6", lat); end
        total++; if (sum !== 9'h046) begin bad++; $display("FAIL persist_sum: got %h want 046", sum); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL persist_err: got %b want 1", err); end
        total++; if (fault_cnt !== 8'd6) begin bad++; $display("FAIL persist_fault_cnt: got %0d want 6", fault_cnt); end
        release_out;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL persist_err_unqualified: got %b want 0", err); end
    endtask

    task test_async_reset;
        int lat;
        // Mid-ADD: sum still holds 0x046 and fault_cnt 6 from the previous op.
        a = 8'hA5; b = 8'h5A; cin = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (sum !== 9'h000) begin bad++; $display("FAIL arst_add_sum: got %h want 000", sum); end
        total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL arst_add_fault_cnt: got %0d want 0", fault_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_add_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL arst_add_in_ready: got %b want 0", in_ready); end
        tick;
        rst = 1'b0;
        tick;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_release_in_ready: got %b want 1", in_ready); end
        run_op(8'hA5, 8'h5A, 1'b1, 0, '0, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL arst_next_latency: got %0d want 2", lat); end
        total++; if (sum !== 9'h100) begin bad++; $display("FAIL arst_next_sum: got %h want 100", sum); end
        release_out;
        // Mid-DONE with err and fault_cnt set.
        run_op(8'h12, 8'h34, 1'b0, 1000, 5'h10, lat);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL arst_done_pre_err: got %b want 1", err); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_done_valid: got %b want 0", out_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL arst_done_err: got %b want 0", err); end
        total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL arst_done_fault_cnt: got %0d want 0", fault_cnt); end
        tick;
        rst = 1'b0;
        tick;
    endtask

    task test_saturation;
        int lat;
        int exp_cnt;
        logic [W:0] exp_sum;
        apply_reset;
        exp_cnt = 0;
        for (int i = 0; i < 43; i++) begin
            run_op(W'(i), W'(255 - i), i[0], 1000, 5'h10, lat);
            exp_cnt = (exp_cnt + 6 > 255) ? 255 : exp_cnt + 6;
            exp_sum = 9'(255 + (i % 2));
            total++; if (sum !== exp_sum) begin bad++; $display("FAIL sat_sum[%0d]: got %h want %h", i, sum, exp_sum); end
            total++; if (fault_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL sat_fault_cnt[%0d]: got %0d want %0d", i, fault_cnt, exp_cnt); end
            total++; if (lat !== 6) begin bad++; $display("FAIL sat_latency[%0d]: got %0d want 6", i, lat); end
            release_out;
        end
        run_op(8'h01, 8'h02, 1'b0, 0, '0, lat);
        total++; if (fault_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", fault_cnt); end
        total++; if (sum !== 9'h003) begin bad++; $display("FAIL sat_clean_sum: got %h want 003", sum); end
        release_out;
    endtask

    task test_back_to_back;
        int lat;
        int mode;
        int exp_cnt;
        int exp_lat;
        int mism;
        int bp;
        int gap;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        logic [CHUNK:0] m;
        logic [W:0] exp_sum;
        logic exp_err;
        apply_reset;
        exp_cnt = 0;
        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            m = (mode == 3) ? '0 : (CHUNK+1)'($urandom_range(1, 31));
            exp_sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            mism = (mode == 1) ? 1 : (mode == 2) ? 6 : 0;
            exp_lat = 2 + ((mode == 1) ? 1 : (mode == 2) ? 4 : 0);
            exp_err = (mode == 2);
            exp_cnt = (exp_cnt + mism > 255) ? 255 : exp_cnt + mism;
            run_op(ra, rb, rc, (mode == 0) ? 0 : (mode == 1) ? 1 : 1000, m, lat);
            // A busy-time offer must be ignored.
            bp = $urandom_range(0, 3);
            in_valid = 1'b1; a = ~ra;
            for (int k = 0; k < bp; k++) tick;
            total++; if (sum !== exp_sum) begin bad++; $display("FAIL rnd_sum[%0d]: got %h want %h", n, sum, exp_sum); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", n, err, exp_err); end
            total++; if (fault_cnt !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL rnd_fault_cnt[%0d]: got %0d want %0d", n, fault_cnt, exp_cnt); end
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, lat, exp_lat); end
            release_out;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rnd_no_early_accept[%0d]: got %b want 1", n, in_ready); end
            in_valid = 1'b0;
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) tick;
        end
    endtask

    initial begin
        test_reset;
        test_no_fault;
        test_backpressure;
        test_single_retry;
        test_persistent_fault;
        test_async_reset;
        test_saturation;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
